// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with strobes and frame counter; define VGA_TEST_PATTERN_EN to add an rgb colour-bar output
module vga_timing_gen #(
  parameter int CW             = 11,
  parameter int HOR_PIXELS     = 1024,
  parameter int HOR_SYNC_START = 1048,
  parameter int HOR_SYNC_END   = 1184,
  parameter int HOR_TOTAL      = 1344,
  parameter int VER_PIXELS     = 768,
  parameter int VER_SYNC_START = 771,
  parameter int VER_SYNC_END   = 777,
  parameter int VER_TOTAL      = 806,
  parameter bit HSYNC_POL      = 1'b1,
  parameter bit VSYNC_POL      = 1'b1,
  parameter int FCW            = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  output logic [CW-1:0]  hcount,
  output logic [CW-1:0]  vcount,
  output logic           hblnk,
  output logic           vblnk,
  output logic           hsync,
  output logic           vsync,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [11:0]    rgb
`endif
);
  if (!(HOR_PIXELS <= HOR_SYNC_START && HOR_SYNC_START < HOR_SYNC_END && HOR_SYNC_END <= HOR_TOTAL)) begin : g_hchk
    $error("vga_timing_gen: horizontal timing parameters out of order");
  end
  if (!(VER_PIXELS <= VER_SYNC_START && VER_SYNC_START < VER_SYNC_END && VER_SYNC_END <= VER_TOTAL)) begin : g_vchk
    $error("vga_timing_gen: vertical timing parameters out of order");
  end
  if (HOR_TOTAL > 2 ** CW || VER_TOTAL > 2 ** CW) begin : g_wchk
    $error("vga_timing_gen: CW too narrow for HOR_TOTAL/VER_TOTAL");
  end
  logic [CW-1:0] hn, vn;
  logic hw, vw, hb, vb, hs, vs;
  // next raster position and its decode; flags are registered from these so they line up with the counters
  always_comb begin
    hw = hcount == CW'(HOR_TOTAL - 1);
    vw = vcount == CW'(VER_TOTAL - 1);
    hn = hw ? '0 : hcount + CW'(1);
    vn = hw ? (vw ? '0 : vcount + CW'(1)) : vcount;
    hb = int'(hn) >= HOR_PIXELS;
    vb = int'(vn) >= VER_PIXELS;
    hs = int'(hn) >= HOR_SYNC_START && int'(hn) < HOR_SYNC_END;
    vs = int'(vn) >= VER_SYNC_START && int'(vn) < VER_SYNC_END;
  end
  // raster state; en low holds everything except the strobes, which drop so a frozen wrap is never replayed
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= !HSYNC_POL;
      vsync       <= !VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (en) begin
      hcount      <= hn;
      vcount      <= vn;
      hblnk       <= hb;
      vblnk       <= vb;
      hsync       <= hs ? HSYNC_POL : !HSYNC_POL;
      vsync       <= vs ? VSYNC_POL : !VSYNC_POL;
      line_start  <= hw;
      frame_start <= hw & vw;
      frame_cnt   <= frame_cnt + FCW'(hw & vw);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  always_comb bar = 3'(int'(hn) / (HOR_PIXELS / 8));
  // eight vertical colour bars, black in blanking
  always_ff @(posedge clk) begin
    if (rst) rgb <= 12'h000;
    else if (en) rgb <= (hb | vb) ? 12'h000 : {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
  end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a small-mode instance and a default-mode instance with inverted hsync
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  int total = 0;
  int bad = 0;
  logic [4:0] s_hcount, s_vcount;
  logic s_hblnk, s_vblnk, s_hsync, s_vsync, s_line_start, s_frame_start;
  logic [1:0] s_frame_cnt;
  logic [10:0] d_hcount, d_vcount;
  logic d_hblnk, d_vblnk, d_hsync, d_vsync, d_line_start, d_frame_start;
  logic [15:0] d_frame_cnt;
`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] s_rgb, d_rgb;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CW(5), .HOR_PIXELS(16), .HOR_SYNC_START(18), .HOR_SYNC_END(22), .HOR_TOTAL(24),
    .VER_PIXELS(8), .VER_SYNC_START(9), .VER_SYNC_END(11), .VER_TOTAL(13),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FCW(2)
  ) u_s (
    .clk(clk), .rst(rst), .en(en), .hcount(s_hcount), .vcount(s_vcount),
    .hblnk(s_hblnk), .vblnk(s_vblnk), .hsync(s_hsync), .vsync(s_vsync),
    .line_start(s_line_start), .frame_start(s_frame_start), .frame_cnt(s_frame_cnt)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(s_rgb)
`endif
  );

  vga_timing_gen #(.HSYNC_POL(1'b0)) u_d (
    .clk(clk), .rst(rst), .en(en), .hcount(d_hcount), .vcount(d_vcount),
    .hblnk(d_hblnk), .vblnk(d_vblnk), .hsync(d_hsync), .vsync(d_vsync),
    .line_start(d_line_start), .frame_start(d_frame_start), .frame_cnt(d_frame_cnt)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(d_rgb)
`endif
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    en = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  function automatic logic [17:0] s_state;
    return {s_hcount, s_vcount, s_hblnk, s_vblnk, s_hsync, s_vsync, s_line_start, s_frame_start, s_frame_cnt};
  endfunction

  task automatic test_reset;
    do_reset;
    total++;
    if (s_state() !== 18'h0) begin
      bad++;
      $display("FAIL reset_small got=%h exp=%h", s_state(), 18'h0);
    end
    total++;
    if ({d_hcount, d_vcount, d_hsync, d_vsync, d_frame_cnt} !== {11'd0, 11'd0, 1'b1, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL reset_default h=%0d v=%0d hs=%b vs=%b fc=%0d exp 0 0 1 0 0", d_hcount, d_vcount, d_hsync, d_vsync, d_frame_cnt);
    end
`ifdef VGA_TEST_PATTERN_EN
    total++;
    if (d_rgb !== 12'h000) begin
      bad++;
      $display("FAIL reset_rgb got=%h exp=000", d_rgb);
    end
`endif
    step(1);
    total++;
    if ({s_hcount, s_vcount, s_line_start, s_frame_start} !== {5'd1, 5'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL first_cycle h=%0d v=%0d ls=%b fs=%b exp 1 0 0 0", s_hcount, s_vcount, s_line_start, s_frame_start);
    end
  endtask

  task automatic test_frame;
    int fs = 0;
    logic [15:0] got, exp;
    do_reset;
    for (int i = 1; i <= 312; i++) begin
      int h, v;
      step(1);
      h = i % 24;
      v = (i / 24) % 13;
      got = {s_hcount, s_vcount, s_hblnk, s_vblnk, s_hsync, s_vsync, s_line_start, s_frame_start};
      exp = {5'(h), 5'(v), h >= 16, v >= 8, h >= 18 && h < 22, v >= 9 && v < 11, h == 0, h == 0 && v == 0};
      if (s_frame_start) fs++;
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL frame_raster i=%0d got=%h exp=%h", i, got, exp);
      end
    end
    total++;
    if (fs != 1 || s_frame_cnt !== 2'd1) begin
      bad++;
      $display("FAIL frame_count strobes=%0d fc=%0d exp 1 1", fs, s_frame_cnt);
    end
  endtask

  task automatic test_sync_default;
    logic [27:0] got, exp;
    do_reset;
    for (int i = 1; i <= 1344; i++) begin
      int h;
      step(1);
      h = i % 1344;
      got = {d_hcount, d_vcount, d_hblnk, d_vblnk, d_hsync, d_vsync, d_line_start, d_frame_start};
      exp = {11'(h), 11'(i / 1344), h >= 1024, 1'b0, !(h >= 1048 && h < 1184), 1'b0, h == 0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL default_line i=%0d got=%h exp=%h", i, got, exp);
      end
`ifdef VGA_TEST_PATTERN_EN
      if (i == 1 || i == 128 || i == 1023 || i == 1024) begin
        logic [11:0] er;
        er = (i == 128) ? 12'h00F : (i == 1023) ? 12'hFFF : 12'h000;
        total++;
        if (d_rgb !== er) begin
          bad++;
          $display("FAIL pattern h=%0d got=%h exp=%h", h, d_rgb, er);
        end
      end
`endif
    end
  endtask

  task automatic test_freeze;
    logic [17:0] exp;
    do_reset;
    step(311);
    total++;
    if ({s_hcount, s_vcount} !== {5'd23, 5'd12}) begin
      bad++;
      $display("FAIL freeze_pos h=%0d v=%0d exp 23 12", s_hcount, s_vcount);
    end
    en = 1'b0;
    exp = {5'd23, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    for (int i = 0; i < 20; i++) begin
      step(1);
      total++;
      if (s_state() !== exp) begin
        bad++;
        $display("FAIL freeze_hold c=%0d got=%h exp=%h", i, s_state(), exp);
      end
    end
    en = 1'b1;
    step(1);
    exp = {5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1};
    total++;
    if (s_state() !== exp) begin
      bad++;
      $display("FAIL freeze_resume got=%h exp=%h", s_state(), exp);
    end
    en = 1'b0;
    step(1);
    exp = {5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    total++;
    if (s_state() !== exp) begin
      bad++;
      $display("FAIL freeze_no_replay got=%h exp=%h", s_state(), exp);
    end
    en = 1'b1;
    step(1);
    exp = {5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    total++;
    if (s_state() !== exp) begin
      bad++;
      $display("FAIL freeze_continue got=%h exp=%h", s_state(), exp);
    end
  endtask

  task automatic test_reset_mid;
    int fs = 0;
    do_reset;
    step(312 + 156);
    total++;
    if ({s_hcount, s_vcount, s_frame_cnt} !== {5'd12, 5'd6, 2'd1}) begin
      bad++;
      $display("FAIL mid_pos h=%0d v=%0d fc=%0d exp 12 6 1", s_hcount, s_vcount, s_frame_cnt);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    total++;
    if (s_state() !== 18'h0) begin
      bad++;
      $display("FAIL mid_reset got=%h exp=%h", s_state(), 18'h0);
    end
    for (int i = 0; i < 311; i++) begin
      step(1);
      if (s_frame_start) fs++;
    end
    total++;
    if (fs != 0 || {s_hcount, s_vcount} !== {5'd23, 5'd12}) begin
      bad++;
      $display("FAIL mid_no_strobe strobes=%0d h=%0d v=%0d exp 0 23 12", fs, s_hcount, s_vcount);
    end
    step(1);
    total++;
    if ({s_frame_start, s_frame_cnt} !== {1'b1, 2'd1}) begin
      bad++;
      $display("FAIL mid_first_frame fs=%b fc=%0d exp 1 1", s_frame_start, s_frame_cnt);
    end
  endtask

  task automatic test_fcw_wrap;
    logic [1:0] exp_fc [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset;
    for (int f = 0; f < 5; f++) begin
      step(312);
      total++;
      if ({s_frame_start, s_frame_cnt} !== {1'b1, exp_fc[f]}) begin
        bad++;
        $display("FAIL fcw_wrap frame=%0d fs=%b fc=%0d exp 1 %0d", f, s_frame_start, s_frame_cnt, exp_fc[f]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_sync_default;
    test_freeze;
    test_reset_mid;
    test_fcw_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
